proj_bottom_sketch_sorter: RTL

Downstream consumer of the k-mer hasher stage. Accepts one hashed k-mer signature per cycle and maintains a sorted bottom-S MinHash sketch: the SKETCH_LEN smallest distinct signatures seen since the last clear. At end of sequence it streams the sketch out in ascending order over a valid/ready interface, then self-clears for the next sequence.

---
 rtl/proj_pkg.sv | 8 +
 rtl/proj_bottom_sketch_sorter_if.sv | 26 ++
 rtl/proj_sketch_cell.sv | 40 ++++
 rtl/proj_bottom_sketch_sorter.sv | 95 +++++++++
 4 files changed

// File: rtl/proj_pkg.sv
// Shared constants and types for the k-mer hasher / sketch sorter pipeline.
package proj_pkg;
  localparam int HASHER_SORTER_SIGNATURE = 32;
  localparam int SORTER_SKETCH_LEN       = 8;

  typedef logic [HASHER_SORTER_SIGNATURE-1:0] sig_t;
  typedef enum logic [0:0] {COLLECT = 1'b0, DRAIN = 1'b1} sorter_state_e;
endpackage

// File: rtl/proj_bottom_sketch_sorter_if.sv
// Signature input, sequence control and sketch readout bundle for the sorter.
interface proj_bottom_sketch_sorter_if #(
  parameter int SIG_BITS = 32,
  parameter int CNT_BITS = 4
);
  logic                in_valid;
  logic [SIG_BITS-1:0] in_sig;
  logic                in_ready;
  logic                seq_end;
  logic                start_over;
  logic [CNT_BITS-1:0] count;
  logic                out_valid;
  logic                out_ready;
  logic [SIG_BITS-1:0] out_sig;
  logic                out_last;
  logic                sketch_done;

  modport master (
    output in_valid, in_sig, seq_end, start_over, out_ready,
    input  in_ready, count, out_valid, out_sig, out_last, sketch_done
  );
  modport slave (
    input  in_valid, in_sig, seq_end, start_over, out_ready,
    output in_ready, count, out_valid, out_sig, out_last, sketch_done
  );
endinterface

// File: rtl/proj_sketch_cell.sv
// One sketch slot: compares against the incoming signature and on insert keeps,
// takes its left neighbour (shift up) or takes the new signature.
module proj_sketch_cell #(
  parameter int SIG_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                ins,
  input  logic [SIG_BITS-1:0] in_sig,
  input  logic                left_lt,
  input  logic [SIG_BITS-1:0] left_entry,
  input  logic                left_valid,
  output logic [SIG_BITS-1:0] entry,
  output logic                valid,
  output logic                lt,
  output logic                eq
);
  assign lt = valid && (entry < in_sig);
  assign eq = valid && (entry == in_sig);

  // lt flags form a prefix, so the first non-lt cell after an lt neighbour is the slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry <= '0;
      valid <= 1'b0;
    end else if (clr) begin
      entry <= '0;
      valid <= 1'b0;
    end else if (ins && !lt) begin
      if (left_lt) begin
        entry <= in_sig;
        valid <= 1'b1;
      end else begin
        entry <= left_entry;
        valid <= left_valid;
      end
    end
  end
endmodule

// File: rtl/proj_bottom_sketch_sorter.sv
// Bottom-S MinHash sketch: parallel sorted insert of distinct signatures, then
// ascending valid/ready readout and self-clear.
module proj_bottom_sketch_sorter
  import proj_pkg::*;
#(
  parameter int SIG_BITS   = HASHER_SORTER_SIGNATURE,
  parameter int SKETCH_LEN = SORTER_SKETCH_LEN,
  parameter int CNT_BITS   = $clog2(SKETCH_LEN + 1)
) (
  input  logic clk,
  input  logic rst,
  proj_bottom_sketch_sorter_if.slave bus
);
  localparam logic [0:0] ST_COLLECT = COLLECT;
  localparam logic [0:0] ST_DRAIN   = DRAIN;

  logic [SKETCH_LEN-1:0][SIG_BITS-1:0] entry;
  logic [SKETCH_LEN-1:0]               valid, lt, eq;
  logic [0:0]                          state_q;
  logic [CNT_BITS-1:0]                 count_q, rd_idx_q;
  logic                                done_q;
  logic                                collect, xfer, last, clr, ins;
  logic [SIG_BITS-1:0]                 rd_sig;

  assign collect = (state_q == ST_COLLECT);
  assign last    = !collect && (rd_idx_q == count_q - CNT_BITS'(1));
  assign xfer    = !collect && bus.out_ready;
  assign clr     = bus.start_over || (xfer && last);
  assign ins     = collect && bus.in_valid && !(|eq) && !bus.start_over;

  for (genvar i = 0; i < SKETCH_LEN; i++) begin : g_cell
    logic                left_lt, left_valid;
    logic [SIG_BITS-1:0] left_entry;
    if (i == 0) begin : g_head
      assign left_lt    = 1'b1;
      assign left_valid = 1'b0;
      assign left_entry = '0;
    end else begin : g_body
      assign left_lt    = lt[i-1];
      assign left_valid = valid[i-1];
      assign left_entry = entry[i-1];
    end
    proj_sketch_cell #(.SIG_BITS(SIG_BITS)) u_cell (
      .clk(clk), .rst(rst), .clr(clr), .ins(ins), .in_sig(bus.in_sig),
      .left_lt(left_lt), .left_entry(left_entry), .left_valid(left_valid),
      .entry(entry[i]), .valid(valid[i]), .lt(lt[i]), .eq(eq[i])
    );
  end

  always_comb begin
    rd_sig = '0;
    for (int i = 0; i < SKETCH_LEN; i++)
      if (!collect && valid[i] && rd_idx_q == CNT_BITS'(i)) rd_sig = entry[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_COLLECT;
      count_q  <= '0;
      rd_idx_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.start_over) begin
        state_q  <= ST_COLLECT;
        count_q  <= '0;
        rd_idx_q <= '0;
      end else if (collect) begin
        if (ins && count_q < CNT_BITS'(SKETCH_LEN)) count_q <= count_q + CNT_BITS'(1);
        // an empty sketch skips readout entirely but still reports completion
        if (bus.seq_end) begin
          if (count_q == '0 && !ins) done_q <= 1'b1;
          else begin
            state_q  <= ST_DRAIN;
            rd_idx_q <= '0;
          end
        end
      end else if (xfer) begin
        if (last) begin
          state_q  <= ST_COLLECT;
          count_q  <= '0;
          rd_idx_q <= '0;
          done_q   <= 1'b1;
        end else rd_idx_q <= rd_idx_q + CNT_BITS'(1);
      end
    end
  end

  assign bus.in_ready    = collect && !rst;
  assign bus.count       = count_q;
  assign bus.out_valid   = !collect;
  assign bus.out_sig     = rd_sig;
  assign bus.out_last    = last;
  assign bus.sketch_done = done_q;
endmodule
